systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream stage of systolic_array: turns row-major input (one full row of matrix a per handshake) into the
//  diagonal/skewed stream the array consumes on in_data/in_start/in_valid. Column c of each row is delayed c
//  cycles; unused lanes carry zero. After the last row it drives zero rows so the array drains and raises out_done.
// PARAMETERS
//  BitSize      8  width of one element
//  NumOfInputs  4  elements per row (n); equals array NumOfInputs
//  NumOfNerves  2  array columns (p); sets flush length
// PORTS
//  clk        in   1                   clock, all state on posedge
//  res_n      in   1                   asynchronous active-low reset
//  down_ready in   1                   array out_ready (weights loaded); 0 = freeze
//  in_valid   in   1                   row offered
//  in_last    in   1                   offered row is the last row of the matrix
//  in_data    in   NumOfInputs*BitSize row; column c at bits [(NumOfInputs-c)*BitSize-1 -: BitSize]
//  in_ready   out  1                   row accepted when in_valid && in_ready
//  out_valid  out  1                   to array in_valid
//  out_start  out  1                   to array in_start; high once per real row (m cycles/matrix)
//  out_data   out  NumOfInputs*BitSize to array in_data; same lane packing as in_data
//  out_busy   out  1                   state != IDLE
// BEHAVIOUR
//  - Reset (async, res_n=0): state IDLE, all delay regs 0, flush counter 0; out_valid=0, out_start=0,
//    out_data=0, out_busy=0; in_ready=0 while res_n=0. Reset mid-matrix discards it; no partial output after.
//  - FSM: IDLE -> FEED on accepted row with in_last=0; IDLE/FEED -> FLUSH on accepted row with in_last=1;
//    FLUSH -> IDLE when flush counter reaches NumOfInputs+NumOfNerves-1 advances.
//  - in_ready = down_ready && (state==IDLE || state==FEED) (combinational). Never high in FLUSH.
//  - advance = down_ready && ((IDLE/FEED && in_valid) || FLUSH). Delay regs/counter change only on advance.
//  - Lane c: delay chain of c+1 registers. On advance, stage 0 loads column c of the accepted row (zero in
//    FLUSH), stages shift by one. out_data lane c = last stage of lane c.
//  - Latency: column c of a row accepted at advance k appears on out_data after advance k+c (registered);
//    column 0 appears the cycle after acceptance.
//  - out_valid registered: 1 in cycle after any advance, else 0. out_start registered: 1 in cycle after an
//    advance that accepted a real row. Stall cycles (no advance) hold out_data, drive out_valid=out_start=0;
//    array freezes on in_valid=0 so skew stays aligned.
//  - Per matrix of m rows: exactly m + NumOfInputs+NumOfNerves-1 cycles with out_valid=1, m with out_start=1.
//  - down_ready falling mid-FEED/FLUSH = stall; resume exactly where stopped. in_valid low in FEED = stall.
//  - Single-row matrix (in_last on first row) legal: IDLE -> FLUSH directly.
//  - Next matrix accepted the cycle after FLUSH->IDLE; no overlap of matrices. Widths: no arithmetic on data.
// CONFIGURATION
//  - FEEDER_ROW_COUNT_EN defined: adds port out_rows (out, 16) = row count of the last completed matrix,
//    updated on FLUSH->IDLE, reset 0, saturates at 16'hFFFF; internal row counter clears on matrix start.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING (NumOfInputs=4, NumOfNerves=2, BitSize=8 unless noted)
//  - Reset: res_n=0 mid-FLUSH -> outputs 0, in_ready=0 immediately; after release state IDLE, out_busy=0.
//  - 4x4 matrix rows {00,01,02,03}..{30,31,32,33} back-to-back, in_last on row 3 -> out_data per cycle
//    [00,0,0,0],[10,01,0,0],[20,11,02,0],[30,21,12,03],[0,31,22,13],[0,0,32,23],[0,0,0,33],[0,0,0,0]x2;
//    out_valid=1 for 9 cycles, out_start=1 first 4.
//  - Same matrix with in_valid low 2 cycles after row 1 -> out_valid=0 those cycles, out_data held,
//    remaining sequence identical to previous test.
//  - down_ready dropped 3 cycles mid-FLUSH -> in_ready=0, out_valid=0, no state change; flush completes after.
//  - Single row {AA,BB,CC,DD} with in_last -> out_valid 6 cycles, out_start 1; DD appears on 4th valid cycle.
//  - FEEDER_ROW_COUNT_EN: matrices of 4 then 1 rows -> out_rows=4 then 1 after each FLUSH->IDLE.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Row-major to skewed-diagonal feeder for systolic_array: lane c is delayed c cycles, then zero rows drain the array.
// Optional FEEDER_ROW_COUNT_EN adds out_rows, the row count of the last completed matrix.
module systolic_skew_feeder #(
  parameter int BitSize     = 8,
  parameter int NumOfInputs = 4,
  parameter int NumOfNerves = 2
) (
  input  logic                              clk,
  input  logic                              res_n,
  input  logic                              down_ready,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic [NumOfInputs*BitSize-1:0]    in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic                              out_start,
  output logic [NumOfInputs*BitSize-1:0]    out_data,
  output logic                              out_busy
`ifdef FEEDER_ROW_COUNT_EN
  ,
  output logic [15:0]                       out_rows
`endif
);

  localparam int FlushLen = NumOfInputs + NumOfNerves - 1;
  localparam int CntW     = $clog2(FlushLen + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CntW-1:0] r_flush_cnt;
  logic            r_out_valid;
  logic            r_out_start;
  logic            w_feeding;
  logic            w_accept;
  logic            w_advance;
  logic            w_flush_done;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FEED: if (w_accept) w_state_nxt = in_last ? S_FLUSH : S_FEED;
      S_FLUSH:        if (w_flush_done) w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // in_ready is gated by res_n so it is low for the whole reset, not just after the first edge
  always_comb begin
    w_feeding    = (r_state == S_IDLE) || (r_state == S_FEED);
    in_ready     = res_n && down_ready && w_feeding;
    w_accept     = down_ready && w_feeding && in_valid;
    w_advance    = w_accept || (down_ready && (r_state == S_FLUSH));
    w_flush_done = down_ready && (r_state == S_FLUSH) && (r_flush_cnt == CntW'(FlushLen - 1));
    out_busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_flush_cnt <= '0;
    end else if (w_advance && (r_state == S_FLUSH)) begin
      r_flush_cnt <= w_flush_done ? '0 : r_flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_out_valid <= 1'b0;
      r_out_start <= 1'b0;
    end else begin
      r_out_valid <= w_advance;
      r_out_start <= w_accept;
    end
  end

  assign out_valid = r_out_valid;
  assign out_start = r_out_start;

  // Lane c owns c+1 stages; stalls hold every stage so the skew stays aligned with the frozen array
  for (genvar c = 0; c < NumOfInputs; c++) begin : g_lane
    logic [BitSize-1:0] r_stage [0:c];

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        for (int s = 0; s <= c; s++) r_stage[s] <= '0;
      end else if (w_advance) begin
        r_stage[0] <= w_accept ? in_data[(NumOfInputs-c)*BitSize-1 -: BitSize] : '0;
        for (int s = 1; s <= c; s++) r_stage[s] <= r_stage[s-1];
      end
    end

    assign out_data[(NumOfInputs-c)*BitSize-1 -: BitSize] = r_stage[c];
  end

`ifdef FEEDER_ROW_COUNT_EN
  logic [15:0] r_row_cnt;
  logic [15:0] r_rows;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_row_cnt <= '0;
      r_rows    <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == S_IDLE)          r_row_cnt <= 16'd1;
        else if (r_row_cnt != 16'hFFFF) r_row_cnt <= r_row_cnt + 16'd1;
      end
      if (w_flush_done) r_rows <= r_row_cnt;
    end
  end

  assign out_rows = r_rows;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed skew/stall/reset cases plus randomized matrices
// scored against a history-of-advances reference model.
module tb_systolic_skew_feeder;
  localparam int B  = 8;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int FL = N + P - 1;

  logic           clk = 1'b0;
  logic           res_n;
  logic           down_ready;
  logic           in_valid;
  logic           in_last;
  logic [N*B-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic           out_start;
  logic [N*B-1:0] out_data;
  logic           out_busy;
`ifdef FEEDER_ROW_COUNT_EN
  logic [15:0]    out_rows;
`endif

  systolic_skew_feeder #(.BitSize(B), .NumOfInputs(N), .NumOfNerves(P)) dut (
    .clk(clk), .res_n(res_n), .down_ready(down_ready), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_start(out_start),
    .out_data(out_data), .out_busy(out_busy)
`ifdef FEEDER_ROW_COUNT_EN
    , .out_rows(out_rows)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: every advance pushes the row it injected (zero for flush);
  // lane c of the output is column c of the row pushed c advances earlier.
  logic [N*B-1:0] hist[$];
  int             flush_left = 0;
  bit             mbusy      = 0;
  int             rows       = 0;
  int             rows_done  = 0;
  int             vcnt       = 0;
  int             scnt       = 0;
  bit             capture    = 0;
  logic [N*B-1:0] cap[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*B-1:0] exp_data();
    logic [N*B-1:0] r;
    logic [N*B-1:0] h;
    r = '0;
    for (int c = 0; c < N; c++) begin
      if (hist.size() > c) begin
        h = hist[c];
        r[(N-c)*B-1 -: B] = h[(N-c)*B-1 -: B];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    flush_left = 0;
    mbusy      = 0;
    rows       = 0;
    rows_done  = 0;
    vcnt       = 0;
    scnt       = 0;
  endtask

  // Called at posedge+1: drive, check in_ready mid-cycle, clock, then check registered outputs.
  task automatic cyc(input logic v, input logic last, input logic [N*B-1:0] d, input logic dr,
                     output bit acc);
    bit adv;
    bit mend;
    mend = 0;
    in_valid = v; in_last = last; in_data = d; down_ready = dr;
    @(negedge clk);
    chk("in_ready", in_ready, dr && (flush_left == 0));
    adv = dr && ((flush_left > 0) || v);
    acc = adv && (flush_left == 0);
    @(posedge clk); #1;
    if (adv) begin
      if (acc) begin
        hist.push_front(d);
        if (!mbusy) rows = 0;
        rows++;
        mbusy = 1;
        if (last) flush_left = FL;
      end else begin
        hist.push_front('0);
        flush_left--;
        if (flush_left == 0) begin
          mbusy     = 0;
          rows_done = rows;
          mend      = 1;
        end
      end
      while (hist.size() > N) void'(hist.pop_back());
    end
    chk("out_valid", out_valid, adv);
    chk("out_start", out_start, acc);
    chk("out_data", out_data, exp_data());
    chk("out_busy", out_busy, mbusy);
`ifdef FEEDER_ROW_COUNT_EN
    chk("out_rows", out_rows, rows_done);
`endif
    if (out_valid === 1'b1) vcnt++;
    if (out_start === 1'b1) scnt++;
    if (capture && out_valid === 1'b1) cap.push_back(out_data);
    if (mend) begin
      chk("valid_cycles", vcnt, rows_done + FL);
      chk("start_cycles", scnt, rows_done);
      vcnt = 0;
      scnt = 0;
    end
  endtask

  task automatic feed(input logic [N*B-1:0] d, input logic last, input int pv, input int pr);
    bit acc;
    int tries;
    logic v, dr;
    tries = 0;
    acc   = 0;
    while (!acc && tries < 200) begin
      v  = ($urandom_range(99) < pv);
      dr = ($urandom_range(99) < pr);
      cyc(v, last, d, dr, acc);
      tries++;
    end
    if (!acc) chk("feed_timeout", 0, 1);
  endtask

  task automatic drain(input int pr);
    bit acc;
    int tries;
    logic v, dr;
    tries = 0;
    while (mbusy && tries < 200) begin
      v  = $urandom_range(1);
      dr = ($urandom_range(99) < pr);
      cyc(v, $urandom_range(1), $urandom, dr, acc);
      tries++;
    end
    if (mbusy) chk("drain_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    res_n = 1'b0; in_valid = 1'b1; down_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_start", out_start, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_busy", out_busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", out_busy, 1'b0);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_data", out_data, '0);
`ifdef FEEDER_ROW_COUNT_EN
    chk("post_rst_rows", out_rows, 16'd0);
`endif
  endtask

  task automatic check_table();
    logic [N*B-1:0] tbl [9];
    logic [N*B-1:0] o;
    tbl = '{32'h00000000, 32'h10010000, 32'h20110200, 32'h30211203, 32'h00312213,
            32'h00003223, 32'h00000033, 32'h00000000, 32'h00000000};
    chk("skew_len", cap.size(), 9);
    for (int i = 0; i < 9; i++) begin
      o = (i < cap.size()) ? cap[i] : 'x;
      chk($sformatf("skew_%0d", i), o, tbl[i]);
    end
  endtask

  logic [N*B-1:0] mrow [4];
  bit             dmy;
  int             m;

  initial begin
    mrow = '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233};
    res_n = 1'b0; down_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(posedge clk); #1;
    apply_reset();

    // 4x4 back-to-back
    capture = 1; cap.delete();
    for (int r = 0; r < 4; r++) feed(mrow[r], r == 3, 100, 100);
    drain(100);
    capture = 0;
    check_table();

    // in_valid low for two cycles after row 1
    capture = 1; cap.delete();
    feed(mrow[0], 1'b0, 100, 100);
    feed(mrow[1], 1'b0, 100, 100);
    cyc(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, dmy);
    cyc(1'b0, 1'b0, 32'hDEADBEEF, 1'b1, dmy);
    feed(mrow[2], 1'b0, 100, 100);
    feed(mrow[3], 1'b1, 100, 100);
    drain(100);
    capture = 0;
    check_table();

    // down_ready low for three cycles mid-flush, with rows offered meanwhile
    for (int r = 0; r < 4; r++) feed(mrow[r], r == 3, 100, 100);
    cyc(1'b0, 1'b0, '0, 1'b1, dmy);
    cyc(1'b0, 1'b0, '0, 1'b1, dmy);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 32'h55AA55AA, 1'b0, dmy);
    chk("flush_still_busy", out_busy, 1'b1);
    drain(100);

    // single-row matrix
    capture = 1; cap.delete();
    feed(32'hAABBCCDD, 1'b1, 100, 100);
    drain(100);
    capture = 0;
    chk("single_len", cap.size(), 6);
    chk("single_first", (cap.size() > 0) ? cap[0] : 'x, 32'hAA000000);
    chk("single_dd", (cap.size() > 3) ? cap[3] : 'x, 32'h000000DD);

    // randomized matrices with random stalls and spurious offers during flush
    for (int t = 0; t < 20; t++) begin
      m = $urandom_range(1, 6);
      for (int r = 0; r < m; r++) feed($urandom, r == m - 1, 70, 80);
      drain(80);
      if ($urandom_range(1)) cyc(1'b0, 1'b0, $urandom, $urandom_range(1), dmy);
    end

    // reset in the middle of a flush, then a clean matrix afterwards
    for (int r = 0; r < 3; r++) feed($urandom, r == 2, 100, 100);
    cyc(1'b0, 1'b0, '0, 1'b1, dmy);
    apply_reset();
    for (int r = 0; r < 2; r++) feed($urandom, r == 1, 100, 100);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
